// File: rtl/sudoku_pkg.sv
// Shared Sudoku board constants, sequencer state encoding and cell addressing.
package sudoku_pkg;

  localparam int BLKSIZE = 52;
  localparam int GRID    = 9;

  typedef enum logic [1:0] {
    SIDLE     = 2'd0,
    SSTREAM   = 2'd1,
    SWAIT_RES = 2'd2,
    SWRITE    = 2'd3
  } state_e;

  // Row-major index into the 81-entry board vectors.
  function automatic logic [6:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    return 7'(y) * 7'd9 + 7'(x);
  endfunction

endpackage

// File: rtl/track_row_mux.sv
// Row selector over the latched stroke bitmap, plus an all-zero detector for incoming strokes.
module track_row_mux #(
  parameter int BLKSIZE = 52
) (
  input  logic [BLKSIZE*BLKSIZE-1:0] track_i,
  input  logic [5:0]                 row_idx_i,
  output logic [BLKSIZE-1:0]         row_o,
  input  logic [BLKSIZE*BLKSIZE-1:0] probe_i,
  output logic                       empty_o
);

  always_comb begin
    row_o = '0;
    if (int'(row_idx_i) < BLKSIZE) begin
      row_o = track_i[int'(row_idx_i)*BLKSIZE +: BLKSIZE];
    end
  end

  assign empty_o = ~(|probe_i);

endmodule

// File: rtl/draw_recog_sched.sv
// Sequencer: latches a finished stroke, streams it row-by-row to the recognizer,
// then writes the classified digit to the board or rejects the request.
module draw_recog_sched #(
  parameter int          BLKSIZE = 52,
  parameter logic [31:0] TIMEOUT = 32'd1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       draw_valid,
  input  logic [BLKSIZE*BLKSIZE-1:0] draw_track,
  input  logic [3:0]                 draw_block_x,
  input  logic [3:0]                 draw_block_y,
  input  logic [80:0]                cell_fixed,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic [BLKSIZE-1:0]         row_data,
  output logic [5:0]                 row_idx,
  output logic                       row_last,
  input  logic                       res_valid,
  input  logic [3:0]                 res_digit,
  output logic                       res_ready,
  output logic                       wr_en,
  output logic [3:0]                 wr_x,
  output logic [3:0]                 wr_y,
  output logic [3:0]                 wr_digit,
  output logic                       busy,
  output logic                       reject,
  output logic [7:0]                 drop_cnt
);

  import sudoku_pkg::*;

  localparam logic [5:0] LAST_ROW = 6'(BLKSIZE - 1);

  state_e                     state_q;
  logic [BLKSIZE*BLKSIZE-1:0] track_q;
  logic [3:0]                 x_q;
  logic [3:0]                 y_q;
  logic [3:0]                 digit_q;
  logic [5:0]                 row_idx_q;
  logic [31:0]                tmo_q;
  logic [31:0]                tmo_d;
  logic [7:0]                 drop_q;
  logic                       reject_q;

  logic                       track_empty;
  logic                       cell_ok;
  logic                       fixed_hit;
  logic [6:0]                 cidx;
  logic                       digit_ok;

  track_row_mux #(.BLKSIZE(BLKSIZE)) u_row_mux (
    .track_i   (track_q),
    .row_idx_i (row_idx_q),
    .row_o     (row_data),
    .probe_i   (draw_track),
    .empty_o   (track_empty)
  );

  // Out-of-grid coordinates never index cell_fixed.
  always_comb begin
    cell_ok   = (draw_block_x < 4'(GRID)) && (draw_block_y < 4'(GRID));
    cidx      = cell_idx(draw_block_x, draw_block_y);
    fixed_hit = 1'b0;
    if (cell_ok) begin
      fixed_hit = cell_fixed[cidx];
    end
    digit_ok  = (res_digit != 4'd0) && (res_digit < 4'd10);
    tmo_d     = tmo_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SIDLE;
      track_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      digit_q   <= '0;
      row_idx_q <= '0;
      tmo_q     <= '0;
      drop_q    <= '0;
      reject_q  <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      if (draw_valid && (state_q != SIDLE) && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
      case (state_q)
        SIDLE: begin
          if (draw_valid) begin
            track_q   <= draw_track;
            x_q       <= draw_block_x;
            y_q       <= draw_block_y;
            row_idx_q <= '0;
            if (!cell_ok || fixed_hit) begin
              reject_q <= 1'b1;
            end else if (track_empty) begin
              digit_q <= 4'd0;
              state_q <= SWRITE;
            end else begin
              state_q <= SSTREAM;
            end
          end
        end
        SSTREAM: begin
          if (row_ready) begin
            if (row_idx_q == LAST_ROW) begin
              tmo_q   <= '0;
              state_q <= SWAIT_RES;
            end else begin
              row_idx_q <= row_idx_q + 6'd1;
            end
          end
        end
        SWAIT_RES: begin
          tmo_q <= tmo_d;
          if (res_valid) begin
            if (digit_ok) begin
              digit_q <= res_digit;
              state_q <= SWRITE;
            end else begin
              reject_q <= 1'b1;
              state_q  <= SIDLE;
            end
          end else if (tmo_d == TIMEOUT) begin
            reject_q <= 1'b1;
            state_q  <= SIDLE;
          end
        end
        SWRITE: begin
          state_q <= SIDLE;
        end
        default: begin
          state_q <= SIDLE;
        end
      endcase
    end
  end

  assign row_valid = (state_q == SSTREAM);
  assign row_idx   = row_idx_q;
  assign row_last  = (state_q == SSTREAM) && (row_idx_q == LAST_ROW);
  assign res_ready = (state_q == SWAIT_RES);
  assign wr_en     = (state_q == SWRITE);
  assign wr_x      = x_q;
  assign wr_y      = y_q;
  assign wr_digit  = digit_q;
  assign busy      = (state_q != SIDLE);
  assign reject    = reject_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_draw_recog_sched.sv
// Directed bench for draw_recog_sched: vector table of requests plus drop/reset sequences.
module tb_draw_recog_sched;

  localparam int B  = 52;
  localparam int NB = B * B;

  logic          clk = 1'b0;
  logic          rst;
  logic          draw_valid;
  logic [NB-1:0] draw_track;
  logic [3:0]    bx;
  logic [3:0]    by;
  logic [80:0]   cell_fixed;
  logic          row_valid;
  logic          row_ready;
  logic [B-1:0]  row_data;
  logic [5:0]    row_idx;
  logic          row_last;
  logic          res_valid;
  logic [3:0]    res_digit;
  logic          res_ready;
  logic          wr_en;
  logic [3:0]    wr_x;
  logic [3:0]    wr_y;
  logic [3:0]    wr_digit;
  logic          busy;
  logic          reject;
  logic [7:0]    drop_cnt;

  draw_recog_sched #(.BLKSIZE(B), .TIMEOUT(32'd100)) dut (
    .clk          (clk),
    .rst          (rst),
    .draw_valid   (draw_valid),
    .draw_track   (draw_track),
    .draw_block_x (bx),
    .draw_block_y (by),
    .cell_fixed   (cell_fixed),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .row_data     (row_data),
    .row_idx      (row_idx),
    .row_last     (row_last),
    .res_valid    (res_valid),
    .res_digit    (res_digit),
    .res_ready    (res_ready),
    .wr_en        (wr_en),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_digit     (wr_digit),
    .busy         (busy),
    .reject       (reject),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    int         pr;        // set pixel row, -1 = empty stroke
    int         pc;
    int         fixed_idx; // -1 = no fixed cells
    logic [3:0] dig;
    bit         respond;
    bit         toggle;
    int         exp_hs;
    int         exp_wr;
    int         exp_rej;
    logic [3:0] exp_digit;
    int         exp_lat;   // cycles after draw_valid, 0 = not checked
  } vec_t;

  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] x, input logic [3:0] y, input int pr, input int pc,
                              input int fi, input logic [3:0] dig, input bit resp, input bit tog,
                              input int hs, input int wr, input int rj, input logic [3:0] ed,
                              input int lat);
    vec_t v;
    v.x = x; v.y = y; v.pr = pr; v.pc = pc; v.fixed_idx = fi; v.dig = dig;
    v.respond = resp; v.toggle = tog; v.exp_hs = hs; v.exp_wr = wr; v.exp_rej = rj;
    v.exp_digit = ed; v.exp_lat = lat;
    return v;
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, " row_valid"}, 64'(row_valid), 64'd0);
    chk({tag, " row_last"},  64'(row_last),  64'd0);
    chk({tag, " res_ready"}, 64'(res_ready), 64'd0);
    chk({tag, " wr_en"},     64'(wr_en),     64'd0);
    chk({tag, " reject"},    64'(reject),    64'd0);
    chk({tag, " busy"},      64'(busy),      64'd0);
    chk({tag, " row_idx"},   64'(row_idx),   64'd0);
    chk({tag, " row_data"},  64'(row_data),  64'd0);
    chk({tag, " wr_xyd"},    64'({wr_x, wr_y, wr_digit}), 64'd0);
    chk({tag, " drop_cnt"},  64'(drop_cnt),  64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [NB-1:0] trk;
    logic [80:0]   fx;
    logic [B-1:0]  er;
    logic [B-1:0]  prev_data;
    logic [5:0]    prev_idx;
    int            hs, wrc, rjc, lat, first_rv, res_cnt, after;
    bit            done, prev_stall;
    trk = '0;
    if (v.pr >= 0) trk[v.pr*B + v.pc] = 1'b1;
    fx = '0;
    if (v.fixed_idx >= 0) fx[v.fixed_idx] = 1'b1;
    hs = 0; wrc = 0; rjc = 0; lat = 0; first_rv = 0; res_cnt = 0; after = 0;
    done = 0; prev_stall = 0; prev_idx = '0; prev_data = '0;
    @(negedge clk);
    draw_valid = 1'b1; draw_track = trk; bx = v.x; by = v.y; cell_fixed = fx;
    for (int cyc = 1; cyc <= 400 && after < 3; cyc++) begin
      @(negedge clk);
      // Inputs change after acceptance; the latched request must not follow them.
      draw_valid = 1'b0; draw_track = '0; bx = 4'd0; by = 4'd0; cell_fixed = '1;
      row_ready = v.toggle ? (cyc % 3 != 2) : 1'b1;
      res_valid = 1'b0; res_digit = 4'd0;
      if (res_ready) begin
        res_cnt++;
        if (res_cnt == 2 && v.respond) begin
          res_valid = 1'b1; res_digit = v.dig;
        end
      end
      if (row_valid) begin
        if (first_rv == 0) first_rv = cyc;
        er = (int'(row_idx) == v.pr) ? (52'b1 << v.pc) : '0;
        chk($sformatf("v%0d row_data[%0d]", n, row_idx), 64'(row_data), 64'(er));
        chk($sformatf("v%0d row_last", n), 64'(row_last), 64'(row_idx == 6'd51));
        if (prev_stall) begin
          chk($sformatf("v%0d stall row_idx", n), 64'(row_idx), 64'(prev_idx));
          chk($sformatf("v%0d stall row_data", n), 64'(row_data), 64'(prev_data));
        end
        if (row_ready) begin
          chk($sformatf("v%0d hs order", n), 64'(row_idx), 64'(hs));
          hs++;
        end
        prev_stall = !row_ready; prev_idx = row_idx; prev_data = row_data;
      end else begin
        prev_stall = 0;
      end
      if (wr_en) begin
        wrc++; lat = cyc;
        chk($sformatf("v%0d wr_x", n), 64'(wr_x), 64'(v.x));
        chk($sformatf("v%0d wr_y", n), 64'(wr_y), 64'(v.y));
        chk($sformatf("v%0d wr_digit", n), 64'(wr_digit), 64'(v.exp_digit));
        chk($sformatf("v%0d wr/reject excl", n), 64'(reject), 64'd0);
      end
      if (reject) begin
        rjc++; lat = cyc;
      end
      if (done) after++;
      if (wr_en || reject) done = 1;
    end
    chk($sformatf("v%0d finished in budget", n), 64'(done), 64'd1);
    chk($sformatf("v%0d handshakes", n), 64'(hs), 64'(v.exp_hs));
    chk($sformatf("v%0d wr_en count", n), 64'(wrc), 64'(v.exp_wr));
    chk($sformatf("v%0d reject count", n), 64'(rjc), 64'(v.exp_rej));
    if (v.exp_lat != 0) chk($sformatf("v%0d latency", n), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("v%0d first row_valid cycle", n), 64'(first_rv), (v.exp_hs > 0) ? 64'd1 : 64'd0);
    chk($sformatf("v%0d busy after", n), 64'(busy), 64'd0);
    chk($sformatf("v%0d drop_cnt", n), 64'(drop_cnt), 64'd0);
    cell_fixed = '0; row_ready = 1'b1;
  endtask

  initial begin
    logic [NB-1:0] t;
    int            wrc, rjc, bsy;
    rst = 1'b1; draw_valid = 1'b0; draw_track = '0; bx = '0; by = '0; cell_fixed = '0;
    row_ready = 1'b1; res_valid = 1'b0; res_digit = '0;
    repeat (2) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;

    //            x     y     pr  pc  fix  dig   rsp tog hs  wr rj  dig   lat
    vecs[0] = mk(4'd3, 4'd4, 10, 20, -1, 4'd7,  1, 0, 52, 1, 0, 4'd7, 55);
    vecs[1] = mk(4'd0, 4'd8, -1,  0, -1, 4'd0,  1, 0,  0, 1, 0, 4'd0,  1);
    vecs[2] = mk(4'd9, 4'd0,  5,  5, -1, 4'd0,  1, 0,  0, 0, 1, 4'd0,  1);
    vecs[3] = mk(4'd4, 4'd4,  1,  1, 40, 4'd3,  1, 0,  0, 0, 1, 4'd0,  1);
    vecs[4] = mk(4'd2, 4'd7, 51, 51, -1, 4'd0,  1, 0, 52, 0, 1, 4'd0, 55);
    vecs[5] = mk(4'd8, 4'd8,  0,  0, -1, 4'd12, 1, 0, 52, 0, 1, 4'd0, 55);
    vecs[6] = mk(4'd1, 4'd2, 30,  3, -1, 4'd9,  1, 1, 52, 1, 0, 4'd9,  0);
    vecs[7] = mk(4'd5, 4'd6,  7, 40, -1, 4'd4,  0, 0, 52, 0, 1, 4'd0, 153);
    vecs[8] = mk(4'd6, 4'd1,  0, 51, -1, 4'd1,  1, 0, 52, 1, 0, 4'd1, 55);
    vecs[9] = mk(4'd0, 4'd15, 3,  3, -1, 4'd5,  1, 0,  0, 0, 1, 4'd0,  1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Stall in STREAM and hammer draw_valid while busy.
    t = '0; t[2*B + 3] = 1'b1;
    @(negedge clk);
    row_ready = 1'b0; draw_valid = 1'b1; draw_track = t; bx = 4'd1; by = 4'd1;
    t = '0; t[0] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      draw_valid = 1'b1; draw_track = t; bx = 4'd7; by = 4'd7;
    end
    @(negedge clk);
    draw_valid = 1'b0;
    chk("drop_cnt saturated", 64'(drop_cnt), 64'd255);
    chk("drop row_valid", 64'(row_valid), 64'd1);
    chk("drop row_idx held", 64'(row_idx), 64'd0);
    chk("drop row_data held", 64'(row_data), 64'd0);
    chk("drop wr_x held", 64'(wr_x), 64'd1);

    // Reset mid-STREAM aborts without write or reject.
    rst = 1'b1; row_ready = 1'b1;
    @(negedge clk);
    chk_idle_zero("mid-rst");
    rst = 1'b0;
    wrc = 0; rjc = 0; bsy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wr_en) wrc++;
      if (reject) rjc++;
      if (busy) bsy++;
    end
    chk("post-rst wr_en", 64'(wrc), 64'd0);
    chk("post-rst reject", 64'(rjc), 64'd0);
    chk("post-rst busy", 64'(bsy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
